// File: rtl/traffic_phase_sequencer.sv
// Timed NS-green / clearance / EW-green / clearance phase generator for the light controller.
// Registered cmd (1-cycle after state decision); greens rest while the opposing side has no request.
module traffic_phase_sequencer #(
  parameter int CNT_W          = 8,
  parameter int TICK_DIV       = 1,
  parameter int NS_GREEN_TICKS = 20,
  parameter int EW_GREEN_TICKS = 20,
  parameter int ALL_RED_TICKS  = 3
) (
  input  logic             clka,
  input  logic             reseta,
  input  logic             enable,
  input  logic             ns_req,
  input  logic             ew_req,
  input  logic             force_red,
  output logic [1:0]       cmd,
  output logic             cmd_change,
  output logic [CNT_W-1:0] phase_remaining
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] NS_LOAD = CNT_W'(NS_GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] EW_LOAD = CNT_W'(EW_GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] AR_LOAD = CNT_W'(ALL_RED_TICKS - 1);

  localparam logic [1:0] CMD_RED = 2'b00;
  localparam logic [1:0] CMD_EW  = 2'b01;
  localparam logic [1:0] CMD_NS  = 2'b10;

  typedef enum logic [2:0] {
    INIT_RED     = 3'd0,
    NS_GREEN     = 3'd1,
    RED_AFTER_NS = 3'd2,
    EW_GREEN     = 3'd3,
    RED_AFTER_EW = 3'd4,
    HOLD_RED     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             ns_pending_q, ns_pending_d;
  logic             ew_pending_q, ew_pending_d;
  logic [1:0]       cmd_q, cmd_d;
  logic             cmd_change_q, cmd_change_d;
  logic             tick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    tick    = enable && (pre_q == PRE_MAX);

    if (force_red) begin
      // Counter and prescaler freeze for the whole emergency hold.
      state_d = HOLD_RED;
    end else if (state_q == HOLD_RED) begin
      state_d = INIT_RED;
      cnt_d   = AR_LOAD;
      pre_d   = '0;
    end else if (enable) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          case (state_q)
            INIT_RED: begin
              state_d = NS_GREEN;
              cnt_d   = NS_LOAD;
            end
            NS_GREEN: begin
              if (ew_pending_q) begin
                state_d = RED_AFTER_NS;
                cnt_d   = AR_LOAD;
              end else begin
                cnt_d = NS_LOAD;
              end
            end
            RED_AFTER_NS: begin
              state_d = EW_GREEN;
              cnt_d   = EW_LOAD;
            end
            EW_GREEN: begin
              if (ns_pending_q) begin
                state_d = RED_AFTER_EW;
                cnt_d   = AR_LOAD;
              end else begin
                cnt_d = EW_LOAD;
              end
            end
            RED_AFTER_EW: begin
              state_d = NS_GREEN;
              cnt_d   = NS_LOAD;
            end
            default: begin
              state_d = INIT_RED;
              cnt_d   = AR_LOAD;
            end
          endcase
        end
      end
    end
  end

  // Requests latch outside their own green; entry into that green clears and wins.
  always_comb begin
    ns_pending_d = ns_pending_q | (ns_req && (state_q != NS_GREEN));
    ew_pending_d = ew_pending_q | (ew_req && (state_q != EW_GREEN));
    if ((state_d == NS_GREEN) && (state_q != NS_GREEN)) ns_pending_d = 1'b0;
    if ((state_d == EW_GREEN) && (state_q != EW_GREEN)) ew_pending_d = 1'b0;
  end

  always_comb begin
    case (state_d)
      NS_GREEN: cmd_d = CMD_NS;
      EW_GREEN: cmd_d = CMD_EW;
      default:  cmd_d = CMD_RED;
    endcase
    cmd_change_d = (cmd_d != cmd_q);
  end

  always_ff @(posedge clka or posedge reseta) begin
    if (reseta) begin
      state_q      <= INIT_RED;
      cnt_q        <= AR_LOAD;
      pre_q        <= '0;
      ns_pending_q <= 1'b0;
      ew_pending_q <= 1'b0;
      cmd_q        <= CMD_RED;
      cmd_change_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      ns_pending_q <= ns_pending_d;
      ew_pending_q <= ew_pending_d;
      cmd_q        <= cmd_d;
      cmd_change_q <= cmd_change_d;
    end
  end

  assign cmd             = cmd_q;
  assign cmd_change      = cmd_change_q;
  assign phase_remaining = cnt_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench: instance a (TICK_DIV=1) covers sequencing, requests, force_red and reset;
// instance b (TICK_DIV=3) covers prescaling and enable freeze.
module tb_traffic_phase_sequencer;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic reseta, enable, ns_req, ew_req, force_red;
  logic rst_b, en_b, ns_b, ew_b, force_b;
  logic [1:0] cmd_a, cmd_b;
  logic       chg_a, chg_b;
  logic [7:0] rem_a, rem_b;

  int n_tests = 0;
  int n_fail  = 0;
  int prev_cmd [2];

  traffic_phase_sequencer #(
    .CNT_W(8), .TICK_DIV(1), .NS_GREEN_TICKS(4), .EW_GREEN_TICKS(3), .ALL_RED_TICKS(2)
  ) u_dut_a (
    .clka(clka), .reseta(reseta), .enable(enable), .ns_req(ns_req), .ew_req(ew_req),
    .force_red(force_red), .cmd(cmd_a), .cmd_change(chg_a), .phase_remaining(rem_a)
  );

  traffic_phase_sequencer #(
    .CNT_W(8), .TICK_DIV(3), .NS_GREEN_TICKS(4), .EW_GREEN_TICKS(3), .ALL_RED_TICKS(2)
  ) u_dut_b (
    .clka(clka), .reseta(rst_b), .enable(en_b), .ns_req(ns_b), .ew_req(ew_b),
    .force_red(force_b), .cmd(cmd_b), .cmd_change(chg_b), .phase_remaining(rem_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  // One character per clock edge: expected cmd and expected phase_remaining.
  // The expected cmd_change pulse follows from the previous expected cmd.
  task automatic expect_seq(input string tag, input int sel, input string cmds, input string rems);
    int ec, er, oc, og, orm;
    for (int i = 0; i < cmds.len(); i++) begin
      step();
      ec  = int'(cmds[i]) - 48;
      er  = int'(rems[i]) - 48;
      oc  = sel ? int'(cmd_b) : int'(cmd_a);
      og  = sel ? int'(chg_b) : int'(chg_a);
      orm = sel ? int'(rem_b) : int'(rem_a);
      check($sformatf("%s[%0d].cmd", tag, i), oc, ec);
      check($sformatf("%s[%0d].cmd_change", tag, i), og, (ec != prev_cmd[sel]) ? 1 : 0);
      check($sformatf("%s[%0d].remaining", tag, i), orm, er);
      prev_cmd[sel] = ec;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reseta = 1'b1; enable = 1'b1; ns_req = 1'b0; ew_req = 1'b0; force_red = 1'b0;
    rst_b  = 1'b1; en_b   = 1'b1; ns_b   = 1'b0; ew_b   = 1'b0; force_b   = 1'b0;
    prev_cmd[0] = 0;
    prev_cmd[1] = 0;
    repeat (3) step();
    check("rst_a.cmd", int'(cmd_a), 0);
    check("rst_a.cmd_change", int'(chg_a), 0);
    check("rst_a.remaining", int'(rem_a), 1);
    check("rst_b.remaining", int'(rem_b), 1);

    // Power-up clearance then NS green resting with no requests.
    reseta = 1'b0;
    expect_seq("s1", 0, "02222222222222", "03210321032103");

    // EW request pulse during NS green, then an NS request pulse during EW green.
    ew_req = 1'b1;
    expect_seq("s2_ew", 0, "2", "2");
    ew_req = 1'b0;
    expect_seq("s2_to_ew", 0, "22001111111", "10102102102");
    ns_req = 1'b1;
    expect_seq("s2_ns", 0, "1", "1");
    ns_req = 1'b0;
    expect_seq("s2_to_ns", 0, "1002222222", "0103210321");

    // Both sensors held: 11-cycle cycle, always via all-red.
    ns_req = 1'b1;
    ew_req = 1'b1;
    expect_seq("s3", 0, "20011100222200111002222", "01021010321010210103210");
    ns_req = 1'b0;
    ew_req = 1'b0;
    expect_seq("s4_pre", 0, "0011", "1021");

    // Emergency red for 5 cycles mid EW green.
    force_red = 1'b1;
    expect_seq("s4_hold", 0, "00000", "11111");
    force_red = 1'b0;
    expect_seq("s4_exit", 0, "0022222", "1032103");

    // Async reset in RED_AFTER_NS with an EW request pending.
    ew_req = 1'b1;
    expect_seq("s6_req", 0, "2", "2");
    ew_req = 1'b0;
    expect_seq("s6_pre", 0, "220", "101");
    #2;
    reseta = 1'b1;
    #1;
    check("s6_async.cmd", int'(cmd_a), 0);
    check("s6_async.cmd_change", int'(chg_a), 0);
    check("s6_async.remaining", int'(rem_a), 1);
    step();
    reseta = 1'b0;
    prev_cmd[0] = 0;
    expect_seq("s6_after", 0, "02222222", "03210321");

    // Prescaled instance: NS green spans 16 cycles with a 4-cycle enable gap.
    rst_b = 1'b0;
    ew_b  = 1'b1;
    expect_seq("s5_init", 1, "0", "1");
    ew_b = 1'b0;
    expect_seq("s5_red", 1, "00002", "10003");
    expect_seq("s5_ns1", 1, "2222", "3322");
    en_b = 1'b0;
    expect_seq("s5_frozen", 1, "2222", "2222");
    en_b = 1'b1;
    expect_seq("s5_ns2", 1, "2222222", "2111000");
    expect_seq("s5_clear", 1, "0000", "1110");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
Timed phase generator that drives the 2-bit command input of the intersection light controller. Encoding: 00 = all red, 01 = east-west green, 10 = north-south green.
Sequences NS green, all-red clearance, EW green, all-red clearance. Green is held while the opposing direction has no pending vehicle request. An emergency force-red overrides everything. It sits between the sensor/prescaler logic and the light controller.

Parameters:
CNT_W, 8, width of phase counter and phase_remaining
TICK_DIV, 1, clka cycles per phase tick (>=1)
NS_GREEN_TICKS, 20, NS green duration in ticks (1..2^CNT_W)
EW_GREEN_TICKS, 20, EW green duration in ticks (1..2^CNT_W)
ALL_RED_TICKS, 3, clearance duration in ticks (1..2^CNT_W)

Ports:
clka  in  1  clock
reseta  in  1  reset
enable  in  1  1 = timing runs; 0 = prescaler and phase counter frozen
ns_req  in  1  NS vehicle sensor, level, synchronous to clka
ew_req  in  1  EW vehicle sensor, level, synchronous to clka
force_red  in  1  emergency all-red, synchronous, highest priority
cmd  out  2  registered command to light controller
cmd_change  out  1  one-cycle pulse, high in the first cycle cmd holds a new value
phase_remaining  out  CNT_W  current phase counter value (ticks left minus 1)

Behaviour:
- Reset: reseta, asynchronous, active-high; clock clka.
- Reset values:
  - state INIT_RED; cmd=00; cmd_change=0
  - phase counter = ALL_RED_TICKS-1; prescaler=0
  - ns_pending=0; ew_pending=0
- Tick generation:
  - Prescaler counts 0..TICK_DIV-1 while enable=1.
  - tick=1 in the cycle the prescaler equals TICK_DIV-1 and enable=1. The prescaler wraps to 0 on that cycle.
  - TICK_DIV=1 means tick every enabled cycle.
- Phase counter:
  - Loaded with duration-1 on phase entry.
  - Decrements on tick when nonzero.
  - Phase expires on a tick with counter==0, so each phase lasts exactly duration ticks.
- States and cmd (cmd is a registered copy of the state encoding, updated on the same edge as the state):
  - INIT_RED (00): on expiry, go to NS_GREEN.
  - NS_GREEN (10): on expiry, if ew_pending go to RED_AFTER_NS; else stay and reload NS_GREEN_TICKS-1 (rest in green).
  - RED_AFTER_NS (00): on expiry, go to EW_GREEN.
  - EW_GREEN (01): on expiry, if ns_pending go to RED_AFTER_EW; else stay and reload EW_GREEN_TICKS-1.
  - RED_AFTER_EW (00): on expiry, go to NS_GREEN.
  - HOLD_RED (00): entered from any state on the edge after force_red=1 is sampled. Stays while force_red=1, counter frozen. On force_red=0, go to INIT_RED with counter loaded ALL_RED_TICKS-1 and prescaler cleared.
- Pending latches:
  - ns_pending is set when ns_req=1 in any state except NS_GREEN, and cleared on the edge entering NS_GREEN. Clear wins if both occur on the same edge. ew_pending is symmetric.
  - Latches are unaffected by enable and force_red.
- cmd never goes directly between 01 and 10; a 00 phase of at least ALL_RED_TICKS ticks always intervenes, including on force_red exit.
- cmd_change = registered (cmd_next != cmd). A rest-in-green reload does not pulse.
- enable=0:
  - state, counter and prescaler hold.
  - force_red still takes effect, and pending latches still set.
- Priority per cycle: reseta > force_red > phase expiry > decrement.
- reseta mid-phase: all outputs return to reset values immediately (asynchronously).

Test Plan:
All scenarios use TICK_DIV=1, NS_GREEN_TICKS=4, EW_GREEN_TICKS=3, ALL_RED_TICKS=2, enable=1, unless stated.
1. Reset release with no requests -> cmd=00, phase_remaining=1,0; after the 2nd edge cmd=10 with cmd_change=1 for one cycle. The cmd=10 phase_remaining pattern starts at 3 and then repeats 3,2,1,0 indefinitely, with no further cmd_change.
2. One-cycle ew_req pulse while in NS green -> at NS expiry cmd=00 for 2 cycles, then 01 for 3 cycles, then rest at 01 (no ns_req). A later ns_req pulse gives 00 for 2 cycles, then 10.
3. ns_req and ew_req held high -> periodic cmd sequence 10×4, 00×2, 01×3, 00×2, repeating every 11 cycles; cmd never steps between 01 and 10 directly.
4. force_red=1 for 5 cycles mid EW green -> cmd=00 on the next edge, held for 5 cycles. After release: 00 for 2 more cycles, then cmd=10; exactly one cmd_change on entry and one on the green.
5. TICK_DIV=3 with enable dropped for 4 cycles inside NS green -> NS green lasts 12 enabled cycles (16 total); phase_remaining and cmd are frozen during the enable=0 window.
6. reseta asserted during RED_AFTER_NS with ew_pending=1 -> cmd=00 and cmd_change=0 immediately. After release the sequence matches scenario 1; the pending request is discarded.
